mac_result_requant: RTL and testbench
=====================================

Name: mac_result_requant

Overview:
- Downstream stage of the NPU MAC unit.
- On each MAC completion pulse it captures the wide signed accumulator and adds a per-output bias. It then applies optional ReLU and an arithmetic right shift with round-half-up, and saturates to int8.
- Results are buffered in a small first-word-fall-through FIFO with a valid/ready interface toward the output writer / activation memory.
- The MAC has no backpressure, so overflow is detected and flagged, never stalled.

Parameters:
- ACC_W, 17, accumulator width; equals 16+(N-1) of the feeding MAC (N=2).
- SHIFT, 4, requantisation right-shift amount, 0..ACC_W-1.
- DEPTH, 4, FIFO depth in entries; power of two, >=2.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-low reset.
- acc_in  input  ACC_W  accumulator value, two's-complement signed; valid when acc_done=1.
- acc_done  input  1  one-cycle completion pulse (MAC PDONE).
- bias  input  8  signed int8 bias, sampled together with acc_in.
- relu_en  input  1  1 = clamp negatives to 0; sampled with acc_in.
- err_clr  input  1  synchronous clear of the sticky error flags.
- out_data  output  8  signed int8 result at FIFO head.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts head when out_valid&out_ready.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- sat_flag  output  1  sticky: some result saturated.
- drop_err  output  1  sticky: some result lost because FIFO full.
- sat_count  output  8  saturation event counter (see Optional Feature).

Behaviour:
- Reset (rst=0, async): pipeline valids=0; FIFO empty; out_valid=0; out_data=0; fifo_count=0; sat_flag=0; drop_err=0; sat_count=0. Reset mid-pipeline discards in-flight results.
- Stage 1 (edge where acc_done=1):
  - s1_sum = sext(acc_in) + sext(bias), width ACC_W+1 (no overflow possible).
  - Latch relu_en; s1_v=1. Otherwise s1_v=0.
  - Back-to-back acc_done every cycle is supported.
- Stage 2 (edge where s1_v=1):
  - r = relu_en ? max(s1_sum,0) : s1_sum.
  - If SHIFT>0: q = (r + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, width ACC_W+2.
  - If SHIFT=0: q = r.
  - Saturate q to [-128,127]; a clamp is a saturation event.
  - Push the result into the FIFO on the same edge.
- Latency: acc_done sampled at edge k -> data in FIFO after edge k+2.
  - If FIFO was empty, out_valid=1 and out_data valid in the cycle after edge k+2.
- FIFO:
  - First-word-fall-through; out_data = head entry; out_data holds its last value when empty.
  - Pop on out_valid&out_ready. Pop when empty is ignored.
  - Push when full with no pop: result dropped, drop_err set, contents unchanged.
  - Simultaneous push and pop when full: both happen; count unchanged; no drop.
  - Simultaneous push and pop when empty: push only (pop ignored).
  - Pointers wrap modulo DEPTH. fifo_count reaches DEPTH exactly at full.
- Sticky flags:
  - err_clr=1 clears sat_flag and drop_err at the edge.
  - If a new event occurs on the same edge as err_clr, the set wins.
- Width rule: all arithmetic signed; bias sign-extended; no intermediate truncation before saturation.

Optional Feature:
- Macro REQUANT_SAT_COUNT_EN.
- Defined: sat_count is an 8-bit counter.
  - Increments on each saturation event; saturates at 255 (no wrap).
  - Cleared by reset and by err_clr. A simultaneous event and err_clr yields 1.
- Undefined: sat_count is tied to 0 and no counter logic is built. sat_flag is unaffected.

Test Plan:
- Basic: SHIFT=4, acc_in=256, bias=0, relu_en=0, out_ready=1, pulse at edge k -> out_valid=1 after edge k+2, out_data=0x10, fifo_count=1 for one cycle.
- Rounding/bias: acc_in=24, bias=0 -> 0x02. acc_in=20, bias=-4 -> 0x01. acc_in=-40 (0x1FFD8) -> 0xFE. Same value with relu_en=1 -> 0x00.
- Saturation: acc_in=0x0FFFF -> 0x7F, sat_flag=1. acc_in=0x10000 (-65536) -> 0x80. With REQUANT_SAT_COUNT_EN, sat_count=2. err_clr -> sat_flag=0, sat_count=0.
- Overflow: out_ready=0, 5 back-to-back acc_done (values 16,32,48,64,80) -> fifo_count=4, drop_err=1. Then out_ready=1 -> pops 0x01,0x02,0x03,0x04, fifo_count returns to 0.
- Full with simultaneous push/pop: FIFO full, out_ready=1 on the same cycle a result arrives -> no drop, count stays 4, FIFO order preserved.
- Reset mid-operation: assert rst one cycle after acc_done -> all outputs 0 immediately. After release, no stale result appears and the next acc_done produces a correct result.

Source files
------------

// File: rtl/mac_result_requant.sv
// Requantisation stage behind the NPU MAC: bias add, optional ReLU, rounding shift, int8 saturation, FWFT output FIFO.
// Optional saturation event counter is built when REQUANT_SAT_COUNT_EN is defined; otherwise sat_count is tied to 0.
module mac_result_requant #(
  parameter int ACC_W = 17,
  parameter int SHIFT = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ACC_W-1:0]           acc_in,
  input  logic                       acc_done,
  input  logic [7:0]                 bias,
  input  logic                       relu_en,
  input  logic                       err_clr,
  output logic [7:0]                 out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       sat_flag,
  output logic                       drop_err,
  output logic [7:0]                 sat_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W+1:0] ROUND = (SHIFT > 0) ? ((ACC_W+2)'(1) << RND_SH) : '0;
  localparam logic signed [ACC_W+1:0] QMAX  = (ACC_W+2)'(127);
  localparam logic signed [ACC_W+1:0] QMIN  = -(ACC_W+2)'(128);

  // Stage 1: bias add at full width, so no overflow is possible here
  logic                      s1_v;
  logic signed [ACC_W:0]     s1_sum;
  logic                      s1_relu;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v    <= 1'b0;
      s1_sum  <= '0;
      s1_relu <= 1'b0;
    end else begin
      s1_v <= acc_done;
      if (acc_done) begin
        s1_sum  <= $signed({acc_in[ACC_W-1], acc_in}) + $signed({{(ACC_W-7){bias[7]}}, bias});
        s1_relu <= relu_en;
      end
    end
  end

  // Stage 2: ReLU, round-half-up arithmetic shift, clamp to int8
  logic signed [ACC_W+1:0] r_ext;
  logic signed [ACC_W+1:0] q;
  logic [7:0]              q_sat;
  logic                    q_clamp;

  always_comb begin
    r_ext   = (s1_relu && s1_sum[ACC_W]) ? '0 : {s1_sum[ACC_W], s1_sum};
    q       = (r_ext + ROUND) >>> SHIFT;
    q_sat   = q[7:0];
    q_clamp = 1'b0;
    if (q > QMAX) begin
      q_sat   = 8'h7f;
      q_clamp = 1'b1;
    end else if (q < QMIN) begin
      q_sat   = 8'h80;
      q_clamp = 1'b1;
    end
  end

  logic       s2_v;
  logic [7:0] s2_data;
  logic       s2_sat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_v    <= 1'b0;
      s2_data <= '0;
      s2_sat  <= 1'b0;
    end else begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_data <= q_sat;
        s2_sat  <= q_clamp;
      end
    end
  end

  // FIFO control: the MAC cannot be stalled, so a push into a full FIFO without a pop is dropped
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          full;
  logic          pop;
  logic          do_push;
  logic          drop_ev;
  logic          sat_ev;
  logic [PW-1:0] rd_next;
  logic [CW-1:0] remain;
  logic [CW-1:0] count_next;
  logic [7:0]    head_next;

  assign out_valid  = (count != '0);
  assign fifo_count = count;

  always_comb begin
    full       = (count == CW'(DEPTH));
    pop        = out_valid && out_ready;
    do_push    = s2_v && (!full || pop);
    drop_ev    = s2_v && full && !pop;
    sat_ev     = s2_v && s2_sat;
    rd_next    = pop ? rd_ptr + 1'b1 : rd_ptr;
    remain     = count - CW'(pop);
    count_next = remain + CW'(do_push);
    head_next  = (remain == '0) ? s2_data : mem[rd_next];
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= s2_data;
    end
  end

  // out_data is registered so it keeps the last head value once the FIFO drains
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      rd_ptr <= rd_next;
      count  <= count_next;
      if (count_next != '0) begin
        out_data <= head_next;
      end
    end
  end

  // Sticky flags: a new event on the same edge as err_clr keeps the flag set
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_flag <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      sat_flag <= sat_ev  || (sat_flag && !err_clr);
      drop_err <= drop_ev || (drop_err && !err_clr);
    end
  end

`ifdef REQUANT_SAT_COUNT_EN
  logic [7:0] sat_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sat_cnt <= '0;
    end else if (err_clr) begin
      sat_cnt <= {7'd0, sat_ev};
    end else if (sat_ev && (sat_cnt != 8'hff)) begin
      sat_cnt <= sat_cnt + 8'd1;
    end
  end

  assign sat_count = sat_cnt;
`else
  assign sat_count = '0;
`endif

endmodule

// File: tb/tb_mac_result_requant.sv
// Self-checking bench for mac_result_requant: directed cases plus randomized traffic against a queue-based reference model.
// Honours REQUANT_SAT_COUNT_EN when the same define is given to the bench.
module tb_mac_result_requant;

  localparam int ACC_W = 17;
  localparam int SHIFT = 4;
  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [ACC_W-1:0]       acc_in = '0;
  logic                   acc_done = 1'b0;
  logic [7:0]             bias = '0;
  logic                   relu_en = 1'b0;
  logic                   err_clr = 1'b0;
  logic [7:0]             out_data;
  logic                   out_valid;
  logic                   out_ready = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   sat_flag;
  logic                   drop_err;
  logic [7:0]             sat_count;

  int checks   = 0;
  int failures = 0;

  mac_result_requant #(.ACC_W(ACC_W), .SHIFT(SHIFT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .acc_in(acc_in), .acc_done(acc_done), .bias(bias),
    .relu_en(relu_en), .err_clr(err_clr), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_count(fifo_count), .sat_flag(sat_flag),
    .drop_err(drop_err), .sat_count(sat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         v;
    logic [7:0] d;
    bit         s;
  } item_t;

  // Reference model: results travel through a two-edge delay line, then a bounded queue
  item_t      line[$];
  logic [7:0] m_q[$];
  logic [7:0] m_head;
  bit         m_sat;
  bit         m_drop;
  int         m_cnt;

  function automatic void ref_calc(input longint acc, input longint b, input bit relu,
                                   output logic [7:0] val, output bit sat);
    longint s, d, t, qv;
    s = acc + b;
    if (relu && s < 0) s = 0;
    d = longint'(1) << SHIFT;
    t = s + ((SHIFT > 0) ? d / 2 : 0);
    qv = (t >= 0) ? t / d : -((-t + d - 1) / d);
    sat = 1'b0;
    if (qv > 127) begin
      qv = 127;
      sat = 1'b1;
    end else if (qv < -128) begin
      qv = -128;
      sat = 1'b1;
    end
    val = 8'(qv);
  endfunction

  function automatic void model_reset();
    item_t idle;
    idle.v = 1'b0;
    idle.d = '0;
    idle.s = 1'b0;
    line.delete();
    line.push_back(idle);
    line.push_back(idle);
    m_q.delete();
    m_head = '0;
    m_sat  = 1'b0;
    m_drop = 1'b0;
    m_cnt  = 0;
  endfunction

  function automatic void model_edge();
    item_t arr, nw;
    bit pop, drop_ev, sat_ev;
    if (!rst) begin
      model_reset();
      return;
    end
    arr  = line.pop_front();
    nw.v = acc_done;
    nw.d = '0;
    nw.s = 1'b0;
    if (acc_done) ref_calc(longint'($signed(acc_in)), longint'($signed(bias)), relu_en, nw.d, nw.s);
    line.push_back(nw);
    pop     = (m_q.size() > 0) && out_ready;
    drop_ev = arr.v && (m_q.size() == DEPTH) && !pop;
    if (pop) void'(m_q.pop_front());
    if (arr.v && !drop_ev) m_q.push_back(arr.d);
    if (m_q.size() > 0) m_head = m_q[0];
    sat_ev = arr.v && arr.s;
`ifdef REQUANT_SAT_COUNT_EN
    if (err_clr) m_cnt = sat_ev ? 1 : 0;
    else if (sat_ev && m_cnt < 255) m_cnt++;
`endif
    m_sat  = sat_ev  || (m_sat  && !err_clr);
    m_drop = drop_ev || (m_drop && !err_clr);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check("model_valid", 32'(out_valid), 32'(m_q.size() > 0));
    check("model_data", 32'(out_data), 32'(m_head));
    check("model_count", 32'(fifo_count), 32'(m_q.size()));
    check("model_sat_flag", 32'(sat_flag), 32'(m_sat));
    check("model_drop_err", 32'(drop_err), 32'(m_drop));
    check("model_sat_count", 32'(sat_count), 32'(m_cnt));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_output();
  endtask

  task automatic apply_stimulus(input logic [ACC_W-1:0] a, input logic [7:0] b, input logic r);
    acc_in   = a;
    bias     = b;
    relu_en  = r;
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
  endtask

  task automatic expect_result(input string tag, input logic [ACC_W-1:0] a, input logic [7:0] b,
                               input logic r, input logic [7:0] exp);
    apply_stimulus(a, b, r);
    step();
    step();
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_data"}, 32'(out_data), 32'(exp));
    step();
  endtask

  initial begin
    model_reset();
    #12;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] basic latency");
    out_ready = 1'b1;
    apply_stimulus(17'd256, 8'd0, 1'b0);
    check("basic_k0_valid", 32'(out_valid), 32'd0);
    step();
    check("basic_k1_valid", 32'(out_valid), 32'd0);
    step();
    check("basic_valid", 32'(out_valid), 32'd1);
    check("basic_data", 32'(out_data), 32'h10);
    check("basic_count", 32'(fifo_count), 32'd1);
    step();
    check("basic_drained", 32'(fifo_count), 32'd0);
    check("basic_hold", 32'(out_data), 32'h10);

    $display("[TB] rounding and bias");
    expect_result("round24", 17'd24, 8'd0, 1'b0, 8'h02);
    expect_result("bias_neg", 17'd20, 8'hfc, 1'b0, 8'h01);
    expect_result("neg40", 17'h1ffd8, 8'd0, 1'b0, 8'hfe);
    expect_result("relu", 17'h1ffd8, 8'd0, 1'b1, 8'h00);

    $display("[TB] saturation");
    expect_result("sat_hi", 17'h0ffff, 8'd0, 1'b0, 8'h7f);
    check("sat_flag_set", 32'(sat_flag), 32'd1);
    expect_result("sat_lo", 17'h10000, 8'd0, 1'b0, 8'h80);
`ifdef REQUANT_SAT_COUNT_EN
    check("sat_count_two", 32'(sat_count), 32'd2);
`else
    check("sat_count_tied", 32'(sat_count), 32'd0);
`endif
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("sat_flag_clr", 32'(sat_flag), 32'd0);
    check("sat_count_clr", 32'(sat_count), 32'd0);

    $display("[TB] overflow");
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      acc_in   = ACC_W'(16 * i);
      bias     = '0;
      relu_en  = 1'b0;
      acc_done = 1'b1;
      step();
    end
    acc_done = 1'b0;
    step();
    step();
    check("ovf_count", 32'(fifo_count), 32'(DEPTH));
    check("ovf_drop", 32'(drop_err), 32'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      check("ovf_pop_data", 32'(out_data), 32'(i));
      step();
    end
    check("ovf_empty", 32'(fifo_count), 32'd0);
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    check("drop_clr", 32'(drop_err), 32'd0);

    $display("[TB] full with simultaneous push and pop");
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      acc_in   = ACC_W'(16 * i);
      acc_done = 1'b1;
      step();
    end
    acc_in = 17'd96;
    step();
    acc_done = 1'b0;
    step();
    check("full_count", 32'(fifo_count), 32'(DEPTH));
    out_ready = 1'b1;
    step();
    check("pp_count", 32'(fifo_count), 32'(DEPTH));
    check("pp_nodrop", 32'(drop_err), 32'd0);
    check("pp_head2", 32'(out_data), 32'd2);
    step();
    check("pp_head3", 32'(out_data), 32'd3);
    step();
    check("pp_head4", 32'(out_data), 32'd4);
    step();
    check("pp_head6", 32'(out_data), 32'd6);
    step();
    check("pp_empty", 32'(fifo_count), 32'd0);

    $display("[TB] reset mid-operation");
    apply_stimulus(17'd200, 8'd0, 1'b0);
    rst = 1'b0;
    #1;
    model_reset();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(out_data), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_flags", 32'({sat_flag, drop_err, sat_count}), 32'd0);
    step();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_no_stale", 32'(out_valid), 32'd0);
    end
    expect_result("post_rst", 17'd48, 8'd0, 1'b0, 8'h03);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      acc_done  = ($urandom_range(0, 1) == 1);
      acc_in    = ACC_W'($urandom);
      if ($urandom_range(0, 3) == 0) acc_in = ACC_W'($urandom_range(0, 4095)) - ACC_W'(2048);
      bias      = 8'($urandom);
      relu_en   = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 9) < 6);
      err_clr   = ($urandom_range(0, 19) == 0);
      step();
    end
    acc_done = 1'b0;
    err_clr  = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
